// File: rtl/mic_translator.sv
// ============================================================================
// Module      : mic_translator
// Description : I2S master for a single microphone. It generates BCLK/LRCLK,
//               deserialises left-channel samples and writes them into a
//               circular sample buffer, pulsing start once per full buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module mic_translator #(
   parameter int ADDR_WIDTH = 3,
   parameter int DATA_WIDTH = 18,
   parameter int BCLK_HALF  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  DOUT,
   output logic                  BCLK,
   output logic                  LRCLK,
   output logic                  mic_we,
   output logic [ADDR_WIDTH-1:0] mic_addr,
   output logic [DATA_WIDTH-1:0] mic_data,
   output logic                  start
);

   localparam int                c_div_w    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
   localparam logic [c_div_w-1:0] c_div_max = c_div_w'(BCLK_HALF - 1);
   localparam logic [5:0]        c_last_bit = 6'(DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] c_addr_max = {ADDR_WIDTH{1'b1}};

   logic [c_div_w-1:0]    r_div_cnt;
   logic                  r_bclk;
   logic                  r_lrclk;
   logic [5:0]            r_bit_cnt;
   logic [DATA_WIDTH-1:0] r_shift;
   logic                  r_done;
   logic                  r_we;
   logic                  r_start;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_data;

   logic                  w_div_wrap;
   logic                  w_rise;
   logic                  w_fall;
   logic [5:0]            w_bit_cnt_nxt;
   logic                  w_capture;
   logic                  w_last;

   always_comb begin
      w_div_wrap    = (r_div_cnt == c_div_max);
      w_rise        = w_div_wrap && !r_bclk;
      w_fall        = w_div_wrap && r_bclk;
      w_bit_cnt_nxt = w_fall ? (r_bit_cnt + 6'd1) : r_bit_cnt;
      // The MSB arrives one BCLK after LRCLK falls, hence bit 0 is skipped.
      w_capture     = w_rise && !r_lrclk &&
                      (r_bit_cnt >= 6'd1) && (r_bit_cnt <= c_last_bit);
      w_last        = w_capture && (r_bit_cnt == c_last_bit);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_div_cnt <= '0;
         r_bclk    <= 1'b0;
         r_lrclk   <= 1'b0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_done    <= 1'b0;
         r_we      <= 1'b0;
         r_start   <= 1'b0;
         r_addr    <= '0;
         r_data    <= '0;
      end else begin
         r_div_cnt <= w_div_wrap ? '0 : (r_div_cnt + c_div_w'(1));
         if (w_div_wrap)
            r_bclk <= ~r_bclk;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_lrclk   <= w_bit_cnt_nxt[5];
         if (w_capture)
            r_shift <= {r_shift[DATA_WIDTH-2:0], DOUT};
         // Write strobe lands one cycle after the final bit is shifted in.
         r_done  <= w_last;
         r_we    <= r_done;
         r_start <= r_done && (r_addr == c_addr_max);
         if (r_done)
            r_data <= r_shift;
         if (r_we)
            r_addr <= r_addr + ADDR_WIDTH'(1);
      end
   end

   assign BCLK     = r_bclk;
   assign LRCLK    = r_lrclk;
   assign mic_we   = r_we;
   assign mic_addr = r_addr;
   assign mic_data = r_data;
   assign start    = r_start;

endmodule

`default_nettype wire

// File: tb/tb_mic_translator.sv
// ============================================================================
// Module      : tb_mic_translator
// Description : Directed bench for mic_translator with an edge-indexed
//               timing model of BCLK/LRCLK/write strobes and sample contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mic_translator;

   localparam int AW = 3;
   localparam int DW = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic          DOUT;
   logic          BCLK;
   logic          LRCLK;
   logic          mic_we;
   logic [AW-1:0] mic_addr;
   logic [DW-1:0] mic_data;
   logic          start;

   int            n_cmp = 0;
   int            n_err = 0;
   int            e;
   int            mode;
   int            wr_cnt;
   int            st_cnt;
   logic [DW-1:0] exp_shift;
   logic [DW-1:0] exp_data;
   logic [DW-1:0] pat;

   mic_translator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BCLK_HALF(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .DOUT     (DOUT),
      .BCLK     (BCLK),
      .LRCLK    (LRCLK),
      .mic_we   (mic_we),
      .mic_addr (mic_addr),
      .mic_data (mic_data),
      .start    (start)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, e, obs, expv);
      end
   endtask

   // mode 0: all zeros, 1: all ones, 2: pat on left bits 1..DW else ones, 3: random
   function automatic logic drive_bit(input int ne);
      int r;
      int n;
      if (mode == 0) return 1'b0;
      if (mode == 1) return 1'b1;
      if (mode == 3) return 1'($urandom_range(0, 1));
      if (ne < 2) return 1'b1;
      r = (ne - 2) % 256;
      n = r / 4;
      if (n >= 1 && n <= DW) return pat[DW-n];
      return 1'b1;
   endfunction

   task automatic tick();
      int   ne;
      int   n;
      logic wexp;
      logic sexp;
      int   aexp;
      ne   = rst ? 0 : e + 1;
      DOUT = drive_bit(ne);
      @(posedge clk);
      #1;
      e    = ne;
      wexp = 1'b0;
      sexp = 1'b0;
      if (rst) begin
         exp_shift = '0;
         exp_data  = '0;
      end else begin
         if (e >= 2 && ((e - 2) % 4) == 0) begin
            n = ((e - 2) % 256) / 4;
            if (n >= 1 && n <= DW)
               exp_shift = {exp_shift[DW-2:0], DOUT};
         end
         wexp = (e >= 75) && (((e - 75) % 256) == 0);
         if (wexp) begin
            exp_data = exp_shift;
            sexp     = (((e - 75) / 256) % 8) == 7;
         end
      end
      aexp = (e < 76) ? 0 : ((((e - 76) / 256) + 1) % 8);
      chk("bclk",  32'(BCLK),     32'((e % 4) >= 2));
      chk("lrclk", 32'(LRCLK),    32'(((e / 4) % 64) >= 32));
      chk("we",    32'(mic_we),   32'(wexp));
      chk("start", 32'(start),    32'(sexp));
      chk("addr",  32'(mic_addr), 32'(aexp));
      chk("data",  32'(mic_data), 32'(exp_data));
      if (mic_we) wr_cnt++;
      if (start)  st_cnt++;
   endtask

   task automatic run_to(input int target);
      while (e < target) tick();
   endtask

   initial begin
      rst = 1'b1; DOUT = 1'b0; mode = 1; e = 0;
      exp_shift = '0; exp_data = '0; pat = '0; wr_cnt = 0; st_cnt = 0;
      tick();
      tick();
      chk("rst_outputs", {26'd0, BCLK, LRCLK, mic_we, start, |mic_addr, |mic_data}, 32'd0);
      rst = 1'b0;

      // DOUT stuck high, two frames
      run_to(75);
      chk("ones_we",   32'(mic_we),   32'd1);
      chk("ones_data", 32'(mic_data), 32'h3FFFF);
      chk("ones_addr", 32'(mic_addr), 32'd0);
      run_to(331);
      chk("ones_data2", 32'(mic_data), 32'h3FFFF);
      chk("ones_addr2", 32'(mic_addr), 32'd1);

      // DOUT stuck low
      run_to(512);
      mode = 0;
      run_to(587);
      chk("zeros_data", 32'(mic_data), 32'h00000);
      chk("zeros_addr", 32'(mic_addr), 32'd2);

      // Random data through the buffer wrap
      run_to(768);
      mode = 3;
      run_to(1866);
      chk("pre_start", 32'(start), 32'd0);
      tick();
      chk("wrap_start", 32'(start),    32'd1);
      chk("wrap_addr",  32'(mic_addr), 32'd7);
      tick();
      chk("start_pulse", 32'(start), 32'd0);
      run_to(2123);
      chk("wrapped_addr", 32'(mic_addr), 32'd0);
      run_to(2200);
      chk("write_count", 32'(wr_cnt), 32'd9);
      chk("start_count", 32'(st_cnt), 32'd1);

      // Mid-capture reset, then a known pattern
      run_to(2344);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      wr_cnt = 0;
      mode = 2;
      pat = 18'h2A5A5;
      run_to(74);
      chk("no_partial_write", 32'(wr_cnt), 32'd0);
      tick();
      chk("pat_we",   32'(mic_we),   32'd1);
      chk("pat_data", 32'(mic_data), 32'h2A5A5);
      chk("pat_addr", 32'(mic_addr), 32'd0);
      tick();
      chk("pat_we_off", 32'(mic_we),   32'd0);
      chk("pat_hold",   32'(mic_data), 32'h2A5A5);
      chk("pat_incr",   32'(mic_addr), 32'd1);
      run_to(331);
      chk("pat_data2", 32'(mic_data), 32'h2A5A5);
      chk("pat_addr2", 32'(mic_addr), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
